// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_FAST,
    S_DONE
  } state_t;

  // All divide/remainder encodings have funct3[2] set.
  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the core and the multiply/divide unit.
interface muldiv_if #(parameter int N = 32);
  logic         start;
  logic         abort;
  logic [2:0]   funct3;
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic [4:0]   rd_in;
  logic         busy;
  logic         done;
  logic         wr_en;
  logic [4:0]   rd_out;
  logic [N-1:0] result;

  modport master (
    output start, abort, funct3, op_a, op_b, rd_in,
    input  busy, done, wr_en, rd_out, result
  );

  modport slave (
    input  start, abort, funct3, op_a, op_b, rd_in,
    output busy, done, wr_en, rd_out, result
  );
endinterface

// File: rtl/muldiv_sign_adj.sv
// Conditional two's-complement: y = neg ? -x : x.
module muldiv_sign_adj #(parameter int W = 32) (
  input  logic [W-1:0] x,
  input  logic         neg,
  output logic [W-1:0] y
);
  assign y = neg ? (~x + W'(1)) : x;
endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: N-step shift-add multiply or
// restoring divide on operand magnitudes, sign-corrected on entry to DONE.
//
//  state  | meaning
//  S_IDLE | waiting for start
//  S_BUSY | iterating, one step per clock, N steps
//  S_FAST | divide by zero or signed overflow, result already known
//  S_DONE | result valid, one-cycle done pulse
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int N = 32
) (
  input  logic    clk,
  input  logic    rst,
  muldiv_if.slave bus
);
  localparam int CW = $clog2(N) + 1;

  state_t          state, state_nxt;
  logic [CW-1:0]   count;
  logic [2:0]      f3_q;
  logic [4:0]      rd_q;
  logic            sa_q, sb_q;
  logic [N-1:0]    opr;
  logic [2*N-1:0]  acc;
  logic [N-1:0]    quo;
  logic [N-1:0]    rem;
  logic [N-1:0]    result_q;

  logic            sgn_a_in, sgn_b_in, neg_a_in, neg_b_in;
  logic [N-1:0]    mag_a, mag_b;
  logic            accept, b_zero, ovf, fast_in;
  logic [N-1:0]    fast_val;
  logic            last_step;

  logic [N:0]      sum;
  logic [2*N-1:0]  acc_nxt;
  logic [N:0]      rem_sh, diff;
  logic [N-1:0]    rem_nxt, quo_nxt;
  logic [2*N-1:0]  fix_in, fixed;
  logic            fix_neg;
  logic [N-1:0]    res_sel;

  assign sgn_a_in = (bus.funct3 != F3_MULHU) && (bus.funct3 != F3_DIVU) &&
                    (bus.funct3 != F3_REMU);
  assign sgn_b_in = sgn_a_in && (bus.funct3 != F3_MULHSU);
  assign neg_a_in = sgn_a_in && bus.op_a[N-1];
  assign neg_b_in = sgn_b_in && bus.op_b[N-1];

  muldiv_sign_adj #(.W(N)) u_mag_a (.x(bus.op_a), .neg(neg_a_in), .y(mag_a));
  muldiv_sign_adj #(.W(N)) u_mag_b (.x(bus.op_b), .neg(neg_b_in), .y(mag_b));

  assign accept   = (state == S_IDLE) && bus.start && !bus.abort;
  assign b_zero   = (bus.op_b == '0);
  assign ovf      = ((bus.funct3 == F3_DIV) || (bus.funct3 == F3_REM)) &&
                    (bus.op_a == {1'b1, {(N-1){1'b0}}}) && (bus.op_b == '1);
  assign fast_in  = is_div(bus.funct3) && (b_zero || ovf);
  assign fast_val = bus.funct3[1] ? (b_zero ? bus.op_a : '0)
                                  : (b_zero ? '1 : bus.op_a);

  assign last_step = (state == S_BUSY) && (count == CW'(N - 1));

  // One shift-add multiply step and one restoring divide step.
  always_comb begin
    sum     = {1'b0, acc[2*N-1:N]} + {1'b0, opr};
    acc_nxt = acc[0] ? {sum, acc[N-1:1]} : {1'b0, acc[2*N-1:1]};
    rem_sh  = {rem, quo[N-1]};
    diff    = rem_sh - {1'b0, opr};
    rem_nxt = diff[N] ? rem_sh[N-1:0] : diff[N-1:0];
    quo_nxt = {quo[N-2:0], ~diff[N]};
  end

  // Select the final magnitude and its sign for the result fix-up.
  always_comb begin
    fix_in  = acc_nxt;
    fix_neg = sa_q ^ sb_q;
    if (is_div(f3_q)) begin
      fix_in = f3_q[1] ? {{N{1'b0}}, rem_nxt} : {{N{1'b0}}, quo_nxt};
      if (f3_q[1]) fix_neg = sa_q;
    end
  end

  muldiv_sign_adj #(.W(2*N)) u_fix (.x(fix_in), .neg(fix_neg), .y(fixed));

  assign res_sel = (is_div(f3_q) || (f3_q == F3_MUL)) ? fixed[N-1:0]
                                                       : fixed[2*N-1:N];

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode; abort always wins and returns to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = fast_in ? S_FAST : S_BUSY;
      S_BUSY: begin
        if (bus.abort)      state_nxt = S_IDLE;
        else if (last_step) state_nxt = S_DONE;
      end
      S_FAST: state_nxt = bus.abort ? S_IDLE : S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, iteration and result write on the edge into DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count    <= '0;
      f3_q     <= '0;
      rd_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      opr      <= '0;
      acc      <= '0;
      quo      <= '0;
      rem      <= '0;
      result_q <= '0;
    end else begin
      if (accept) begin
        count <= '0;
        f3_q  <= bus.funct3;
        rd_q  <= bus.rd_in;
        sa_q  <= neg_a_in;
        sb_q  <= neg_b_in;
        opr   <= is_div(bus.funct3) ? mag_b : mag_a;
        acc   <= {{N{1'b0}}, mag_b};
        quo   <= fast_in ? fast_val : mag_a;
        rem   <= '0;
      end else if (state == S_BUSY) begin
        count <= count + CW'(1);
        acc   <= acc_nxt;
        quo   <= quo_nxt;
        rem   <= rem_nxt;
      end
      if (!bus.abort) begin
        if (last_step)              result_q <= res_sel;
        else if (state == S_FAST)   result_q <= quo;
      end
    end
  end

  assign bus.busy   = (state == S_BUSY);
  assign bus.done   = (state == S_DONE) && !bus.abort;
  assign bus.wr_en  = bus.done && (rd_q != 5'd0);
  assign bus.rd_out = rd_q;
  assign bus.result = result_q;

endmodule
